// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encodings (common to serializer and
// deserializer), default word width and the divider sample phase.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b01,
    RECV = 2'b10
  } state_t;

  localparam int          DEF_DATAWIDTH    = 8;
  localparam logic [1:0]  DEF_SAMPLE_PHASE = 2'b11;

endpackage

// File: rtl/spi_s2p_if.sv
// SPI receive-side bundle: serial line and divider phase in, RX FIFO write
// handshake and status out. The master modport drives the serial side and
// FIFO status; the slave modport is the deserializer.
interface spi_s2p_if #(
  parameter int DATAWIDTH = spi_pkg::DEF_DATAWIDTH
);

  logic                 s2p_enable;
  logic [1:0]           cnt;
  logic                 data_in;
  logic                 not_full0;
  logic                 overrun_clr;
  logic                 wen0;
  logic [DATAWIDTH-1:0] wdata0;
  logic                 busy;
  logic                 overrun;

  modport master (
    output s2p_enable, cnt, data_in, not_full0, overrun_clr,
    input  wen0, wdata0, busy, overrun
  );

  modport slave (
    input  s2p_enable, cnt, data_in, not_full0, overrun_clr,
    output wen0, wdata0, busy, overrun
  );

endinterface

// File: rtl/spi_s2p.sv
// SPI receive deserializer. Samples data_in once per SCLK period (when the
// divider phase cnt equals SAMPLE_PHASE), assembles DATAWIDTH-bit words and
// hands each finished word to the RX FIFO through a one-entry hold register.
// Optional build macro SPI_S2P_LSB_FIRST_EN: first received bit lands in
// wdata0[0] instead of the MSB.
module spi_s2p
  import spi_pkg::*;
#(
  parameter int         DATAWIDTH    = DEF_DATAWIDTH,
  parameter logic [1:0] SAMPLE_PHASE = DEF_SAMPLE_PHASE
) (
  input  logic      clk,
  input  logic      rstn,
  spi_s2p_if.slave  bus
);

  localparam int                CNT_W    = (DATAWIDTH > 2) ? $clog2(DATAWIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATAWIDTH - 1);

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATAWIDTH-1:0]   shift;
  logic [DATAWIDTH-1:0]   shift_nxt;
  logic [DATAWIDTH-1:0]   hold;
  logic                   hold_valid;
  logic                   sample;
  logic                   complete;
  logic                   drain;

  // A strobe only counts while receiving with the window still open; the
  // shifted value on the final strobe is itself the completed word.
  always_comb begin
    sample   = (state == RECV) && bus.s2p_enable && (bus.cnt == SAMPLE_PHASE);
    complete = sample && (bit_cnt == LAST_BIT);
    drain    = hold_valid && !bus.wen0 && bus.not_full0;
`ifdef SPI_S2P_LSB_FIRST_EN
    shift_nxt = {bus.data_in, shift[DATAWIDTH-1:1]};
`else
    shift_nxt = {shift[DATAWIDTH-2:0], bus.data_in};
`endif
  end

  // Receive FSM: shifter, bit counter and busy flag; closing the window
  // discards any partially assembled word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt  <= '0;
          bus.busy <= 1'b0;
          if (bus.s2p_enable) state <= RECV;
        end
        RECV: begin
          if (!bus.s2p_enable) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            bus.busy <= 1'b0;
          end else if (sample) begin
            shift <= shift_nxt;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              bus.busy <= 1'b0;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              bus.busy <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          bit_cnt  <= '0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

  // Hold/push path: drains the hold register into the FIFO (never two
  // writes in a row), accepts a new word if the hold is free or draining
  // this edge, otherwise flags a sticky overrun (set beats clear).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold        <= '0;
      hold_valid  <= 1'b0;
      bus.wen0    <= 1'b0;
      bus.wdata0  <= '0;
      bus.overrun <= 1'b0;
    end else begin
      bus.wen0 <= drain;
      if (drain) begin
        bus.wdata0 <= hold;
        hold_valid <= 1'b0;
      end

      if (bus.overrun_clr) bus.overrun <= 1'b0;

      if (complete) begin
        if (!hold_valid || drain) begin
          hold       <= shift_nxt;
          hold_valid <= 1'b1;
        end else begin
          bus.overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_s2p.sv
// Directed self-checking bench for spi_s2p: single word, aborted word, FIFO
// back-pressure, overrun, drain/complete collision and asynchronous reset.
module tb_spi_s2p;

  localparam int         DW = 8;
  localparam logic [1:0] SP = 2'b11;

  logic clk;
  logic rstn;
  int   vectors;
  int   miscompares;
  int   wen_cnt;
  int   wen_base;

  spi_s2p_if #(.DATAWIDTH(DW)) ifc ();

  spi_s2p #(.DATAWIDTH(DW), .SAMPLE_PHASE(SP)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ifc.wen0 === 1'b1) wen_cnt <= wen_cnt + 1;

  // Expected word for a byte sent first-bit-first as written (MSB of w first).
  function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] w);
    logic [DW-1:0] r;
`ifdef SPI_S2P_LSB_FIRST_EN
    for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One strobe carrying bit b; cnt returns to a non-sample phase afterwards.
  task automatic send_bit(input logic b);
    ifc.data_in = b;
    ifc.cnt     = SP;
    tick();
    ifc.cnt     = 2'b00;
  endtask

  // Sends the top n bits of w, MSB of w first on the line.
  task automatic send_bits(input logic [DW-1:0] w, input int n);
    for (int i = DW-1; i >= DW-n; i--) send_bit(w[i]);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    wen_cnt     = 0;
    rstn            = 1'b0;
    ifc.s2p_enable  = 1'b0;
    ifc.cnt         = 2'b00;
    ifc.data_in     = 1'b0;
    ifc.not_full0   = 1'b1;
    ifc.overrun_clr = 1'b0;
    tick(2);
    check("rst_wen0",    ifc.wen0,    0);
    check("rst_wdata0",  ifc.wdata0,  0);
    check("rst_busy",    ifc.busy,    0);
    check("rst_overrun", ifc.overrun, 0);
    rstn = 1'b1;
    tick();

    // Strobe on the entry edge (still IDLE) and off-phase cnt are ignored.
    ifc.s2p_enable = 1'b1;
    ifc.cnt = SP; ifc.data_in = 1'b1;
    tick();
    check("idle_strobe_busy", ifc.busy, 0);
    ifc.cnt = 2'b01;
    tick();
    check("offphase_busy", ifc.busy, 0);
    ifc.cnt = 2'b00;

    // Single word 8'hA5.
    wen_base = wen_cnt;
    send_bits(8'hA5, 1);
    check("a5_busy_1bit", ifc.busy, 1);
    send_bits(8'hA5 << 1, 7);
    check("a5_wen_at_strobe", ifc.wen0, 0);
    check("a5_busy_done", ifc.busy, 0);
    tick();
    check("a5_wen",   ifc.wen0,   1);
    check("a5_wdata", ifc.wdata0, exp_word(8'hA5));
    check("a5_ovr",   ifc.overrun, 0);
    tick();
    check("a5_wen_single", ifc.wen0,   0);
    check("a5_wdata_kept", ifc.wdata0, exp_word(8'hA5));
    check("a5_count", wen_cnt - wen_base, 1);

    // Abort after 5 bits, then a clean 8'h3C.
    wen_base = wen_cnt;
    send_bits(8'hFF, 5);
    check("abort_busy_mid", ifc.busy, 1);
    ifc.s2p_enable = 1'b0;
    tick();
    check("abort_busy_drop", ifc.busy, 0);
    ifc.s2p_enable = 1'b1;
    tick();
    send_bits(8'h3C, 8);
    tick();
    check("3c_wen",   ifc.wen0,   1);
    check("3c_wdata", ifc.wdata0, exp_word(8'h3C));
    tick(2);
    check("3c_count", wen_cnt - wen_base, 1);

    // FIFO full: 8'h11 waits in hold.
    wen_base = wen_cnt;
    ifc.not_full0 = 1'b0;
    send_bits(8'h11, 8);
    tick(10);
    check("full_no_wen", wen_cnt - wen_base, 0);
    ifc.not_full0 = 1'b1;
    tick();
    check("full_wen",   ifc.wen0,   1);
    check("full_wdata", ifc.wdata0, exp_word(8'h11));

    // Overrun: 8'h22 dropped, 8'h11 kept.
    tick();
    wen_base = wen_cnt;
    ifc.not_full0 = 1'b0;
    send_bits(8'h11, 8);
    check("ovr_before", ifc.overrun, 0);
    send_bits(8'h22, 8);
    check("ovr_set", ifc.overrun, 1);
    ifc.not_full0 = 1'b1;
    tick();
    check("ovr_wen",   ifc.wen0,   1);
    check("ovr_wdata", ifc.wdata0, exp_word(8'h11));
    tick(4);
    check("ovr_count",  wen_cnt - wen_base, 1);
    check("ovr_sticky", ifc.overrun, 1);
    ifc.overrun_clr = 1'b1;
    tick();
    ifc.overrun_clr = 1'b0;
    check("ovr_clr", ifc.overrun, 0);

    // Drain and completion on the same edge: 8'h55 then 8'h77, no overrun.
    wen_base = wen_cnt;
    ifc.not_full0 = 1'b0;
    send_bits(8'h55, 8);
    send_bits(8'h77, 7);
    ifc.not_full0 = 1'b1;
    send_bit(1'b1);
    check("coll_wen1",   ifc.wen0,    1);
    check("coll_wdata1", ifc.wdata0,  exp_word(8'h55));
    check("coll_ovr",    ifc.overrun, 0);
    tick();
    check("coll_gap", ifc.wen0, 0);
    tick();
    check("coll_wen2",   ifc.wen0,   1);
    check("coll_wdata2", ifc.wdata0, exp_word(8'h77));
    tick(2);
    check("coll_count", wen_cnt - wen_base, 2);

    // Asynchronous reset with a held word, an overrun and a partial word.
    ifc.not_full0 = 1'b0;
    send_bits(8'hAA, 8);
    send_bits(8'hBB, 8);
    send_bits(8'hC3, 3);
    check("prerst_busy", ifc.busy,    1);
    check("prerst_ovr",  ifc.overrun, 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_wen0",    ifc.wen0,    0);
    check("arst_wdata0",  ifc.wdata0,  0);
    check("arst_busy",    ifc.busy,    0);
    check("arst_overrun", ifc.overrun, 0);
    ifc.s2p_enable = 1'b0;
    ifc.not_full0  = 1'b1;
    tick();
    rstn = 1'b1;
    wen_base = wen_cnt;
    tick(3);
    check("postrst_no_wen", wen_cnt - wen_base, 0);
    ifc.s2p_enable = 1'b1;
    tick();
    send_bits(8'hF0, 8);
    tick();
    check("f0_wen",   ifc.wen0,   1);
    check("f0_wdata", ifc.wdata0, exp_word(8'hF0));
    check("f0_ovr",   ifc.overrun, 0);
    tick(2);
    check("f0_count", wen_cnt - wen_base, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_s2p.md
Name: spi_s2p

Overview:
SPI receive deserializer. It samples the serial input line on a divider-phase strobe, assembles DATAWIDTH-bit words MSB-first, and pushes each completed word into the receive FIFO via a write-enable handshake. It sits between the SPI pad/serial line and the RX FIFO, sharing the clock divider's cnt phase with the transmit serializer.

Parameters:
DATAWIDTH, 8, bits per received word (min 2)
SAMPLE_PHASE, 2'b11, cnt value at which data_in is sampled (one clk strobe per SCLK period)

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
s2p_enable  input  1  receive window open (chip-select active)
cnt  input  2  clock-divider phase; sample strobe = (cnt == SAMPLE_PHASE)
data_in  input  1  serial data line (already synchronised)
not_full0  input  1  RX FIFO can accept a word this cycle
wen0  output  1  RX FIFO write enable, one-cycle pulse per word
wdata0  output  DATAWIDTH  word written with wen0
busy  output  1  high while a word is partially assembled
overrun  output  1  sticky: a completed word was dropped
overrun_clr  input  1  synchronous clear of overrun

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. All outputs 0 (wen0=0, wdata0=0, busy=0, overrun=0); state IDLE; bit_cnt=0; shift register, hold register and hold_valid all 0.
- FSM states: IDLE and RECV.
  - IDLE -> RECV when s2p_enable=1.
  - RECV -> IDLE when s2p_enable=0.
- Dropping s2p_enable mid-word discards the partial word: bit_cnt=0, busy=0, no write.
- In RECV, on each sample strobe: shift <= {shift[DATAWIDTH-2:0], data_in}; bit_cnt increments; busy=1 while 0 < bit_cnt.
- Word completion: on the strobe with bit_cnt==DATAWIDTH-1, the full word {shift, data_in} loads the hold register, hold_valid=1, bit_cnt wraps to 0 and busy=0.
  - Back-to-back words continue with no gap while enabled.
- Push path (independent of FSM, runs in IDLE too):
  - When hold_valid=1, wen0=0 and not_full0=1, the next edge gives wen0=1, wdata0=hold, hold_valid=0.
  - wen0 is never high two consecutive cycles.
  - wdata0 holds its value until the next push.
- Latency: wen0 is asserted 1 clk after the completing strobe edge when not_full0=1.
- FIFO full: hold waits indefinitely; partial reception continues.
- Simultaneous events:
  - Word completes on the same edge the hold drains: new word accepted, no overrun.
  - Word completes while hold_valid=1 and the hold is not draining: new word dropped, overrun <= 1, hold keeps the old word.
  - overrun_clr and a new overrun on the same edge: overrun = 1 (set wins).
- Strobe in IDLE is ignored.
- cnt values other than SAMPLE_PHASE have no effect.

Optional Feature:
SPI_S2P_LSB_FIRST_EN
- Defined: the shifter shifts right (shift <= {data_in, shift[DATAWIDTH-1:1]}), so the first received bit lands in wdata0[0].
- Undefined: MSB-first as above.
- No other timing or handshake differences.

Decomposition:
- Shared package spi_pkg:
  - state encodings (IDLE=2'b01, RECV=2'b10), shared with the serializer;
  - DATAWIDTH default;
  - SAMPLE_PHASE constant.
- No sub-module needed. The shifter/bit counter and the hold/push path are two always blocks in one module.

Test Plan:
- Enable, drive 8 strobes carrying 1,0,1,0,0,1,0,1 with not_full0=1 -> single wen0 pulse 1 clk after 8th strobe, wdata0=8'hA5, overrun=0.
- Drop s2p_enable after 5 bits, re-enable, send 8'h3C -> only one wen0 with wdata0=8'h3C; busy low after drop.
- not_full0=0, receive 8'h11 -> no wen0; raise not_full0 10 clks later -> wen0 next clk with 8'h11.
- not_full0=0, receive 8'h11 then 8'h22 -> overrun=1; raise not_full0 -> wen0 with 8'h11 only; pulse overrun_clr -> overrun=0.
- Hold drains on the same edge the next word 8'h77 completes -> no overrun; both words written, in order.
- Assert rstn low mid-word and mid-hold -> all outputs 0 immediately; following word 8'hF0 received cleanly. With SPI_S2P_LSB_FIRST_EN the same bit stream yields 8'h0F.
